// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART widths and small helpers for the receive-side buffer.
package uart_rx_fifo_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int ERR_CNT_W     = 8;
    localparam int DEFAULT_DEPTH = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x UART_DATA_W storage: synchronous write, asynchronous read.
// No reset so the array can map onto LUT-RAM; stale contents are masked upstream.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [ADDR_W-1:0]      wr_addr_i,
    input  logic [UART_DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]      rd_addr_i,
    output logic [UART_DATA_W-1:0] rd_data_o
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with FWFT read port, sticky overflow and saturating error count.
// Byte visible 1 clk after rx_done rises; a byte arriving while full without a pop is dropped.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_done,
    input  logic                   rx_err,
    input  logic                   clear,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]        count,
    output logic                   full,
    output logic                   empty,
    output logic                   overflow,
    output logic [ERR_CNT_W-1:0]   err_count
);

    logic                   done_q, err_q;
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic                   push, err_inc, pop_en, wr_en;
    logic [UART_DATA_W-1:0] mem_rd_data;

    assign push    = rx_done & ~done_q;
    assign err_inc = rx_err & ~err_q;

    // DEPTH is a power of two and count never exceeds it, so the MSB alone means full.
    assign full     = count_q[ADDR_W];
    assign empty    = (count_q == '0);
    assign rd_valid = ~empty;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign err_count = err_cnt_q;

    assign pop_en = rd_valid & rd_ready & ~clear;
    assign wr_en  = push & (~full | pop_en) & ~clear;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            err_cnt_d  = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            end
            case ({wr_en, pop_en})
                2'b10:   count_d = count_q + (ADDR_W+1)'(1);
                2'b01:   count_d = count_q - (ADDR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (push && !wr_en) begin
                overflow_d = 1'b1;
            end
            if (err_inc) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            done_q     <= rx_done;
            err_q      <= rx_err;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i     (clk),
        .we_i      (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (rx_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (mem_rd_data)
    );

    // Memory is unreset, so an empty FIFO presents zero rather than stale bytes.
    assign rd_data = empty ? '0 : mem_rd_data;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done, rx_err, clear, rd_ready;
    logic       rd_valid, full, empty, overflow;
    logic [7:0] rd_data, err_count;
    logic [4:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .clear     (clear),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .err_count (err_count)
    );

    typedef struct {
        logic [7:0] d;
        logic       done;
        logic       err;
        logic       clr;
        logic       rdy;
        int         e_cnt;
        logic       e_vld;
        logic [7:0] e_dat;
        logic       e_ovf;
        logic [7:0] e_err;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mkv(logic [7:0] d, logic done, logic err, logic clr, logic rdy,
                                 int e_cnt, logic e_vld, logic [7:0] e_dat, logic e_ovf,
                                 logic [7:0] e_err);
        vec_t v;
        v.d = d; v.done = done; v.err = err; v.clr = clr; v.rdy = rdy;
        v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_dat = e_dat; v.e_ovf = e_ovf; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        cyc();
        rx_done = 1'b0;
        cyc();
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; rx_err = 1'b0;
        clear = 1'b0; rd_ready = 1'b0;
        #12;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_data", int'(rd_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_err", int'(err_count), 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Per-cycle vectors; expectations are state after the clock edge.
        tbl[0]  = mkv(8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'd0);
        tbl[1]  = mkv(8'hA5, 1, 0, 0, 0, 1, 1, 8'hA5, 0, 8'd0);
        tbl[2]  = mkv(8'hA5, 1, 0, 0, 0, 1, 1, 8'hA5, 0, 8'd0);
        tbl[3]  = mkv(8'h3C, 1, 0, 0, 0, 1, 1, 8'hA5, 0, 8'd0);
        tbl[4]  = mkv(8'h00, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 8'd0);
        tbl[5]  = mkv(8'h11, 1, 0, 0, 0, 2, 1, 8'hA5, 0, 8'd0);
        tbl[6]  = mkv(8'h00, 0, 0, 0, 1, 1, 1, 8'h11, 0, 8'd0);
        tbl[7]  = mkv(8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'd0);
        tbl[8]  = mkv(8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 8'd0);
        tbl[9]  = mkv(8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'd1);
        tbl[10] = mkv(8'h00, 0, 1, 0, 0, 0, 0, 8'h00, 0, 8'd1);
        tbl[11] = mkv(8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'd1);
        tbl[12] = mkv(8'h22, 1, 1, 0, 0, 1, 1, 8'h22, 0, 8'd2);
        tbl[13] = mkv(8'h00, 0, 0, 0, 0, 1, 1, 8'h22, 0, 8'd2);
        tbl[14] = mkv(8'h33, 1, 1, 1, 1, 0, 0, 8'h00, 0, 8'd0);
        tbl[15] = mkv(8'h33, 1, 1, 0, 0, 0, 0, 8'h00, 0, 8'd0);
        tbl[16] = mkv(8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 0, 8'd0);

        for (int i = 0; i < 17; i++) begin
            rx_data = tbl[i].d; rx_done = tbl[i].done; rx_err = tbl[i].err;
            clear = tbl[i].clr; rd_ready = tbl[i].rdy;
            cyc();
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
            chk($sformatf("v%0d_valid", i), int'(rd_valid), int'(tbl[i].e_vld));
            chk($sformatf("v%0d_data", i), int'(rd_data), int'(tbl[i].e_dat));
            chk($sformatf("v%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
            chk($sformatf("v%0d_err", i), int'(err_count), int'(tbl[i].e_err));
        end
        rx_data = 8'h00; rx_done = 0; rx_err = 0; clear = 0; rd_ready = 0;

        // rx_done held 16 clocks: exactly one entry
        rx_data = 8'hA5; rx_done = 1'b1;
        cyc();
        chk("hold_valid_next", int'(rd_valid), 1);
        chk("hold_data_next", int'(rd_data), 8'hA5);
        for (int i = 1; i < 16; i++) cyc();
        rx_done = 1'b0;
        cyc();
        chk("hold_count", int'(count), 1);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("hold_empty", int'(empty), 1);

        // Fill, overflow, drain in order
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 16);
        chk("fill_ovf0", int'(overflow), 0);
        push_byte(8'h55);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 16);
        chk("ovf_head", int'(rd_data), 8'h00);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), int'(rd_data), i);
            cyc();
        end
        rd_ready = 1'b0;
        chk("drain_empty", int'(empty), 1);
        chk("drain_ovf_sticky", int'(overflow), 1);

        // Saturating error count, then clear wipes everything
        push_byte(8'hE1);
        push_byte(8'hE2);
        for (int i = 0; i < 300; i++) begin
            rx_err = 1'b1; cyc();
            rx_err = 1'b0; cyc();
        end
        chk("err_sat", int'(err_count), 8'hFF);
        chk("err_no_push", int'(count), 2);
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("clr_err", int'(err_count), 0);
        chk("clr_ovf", int'(overflow), 0);
        chk("clr_count", int'(count), 0);
        chk("clr_valid", int'(rd_valid), 0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i));
        rx_data = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
        cyc();
        rx_done = 1'b0; rd_ready = 1'b0;
        chk("fullpp_count", int'(count), 16);
        chk("fullpp_ovf", int'(overflow), 0);
        cyc();
        rd_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("fullpp_rd%0d", i), int'(rd_data), 8'h80 + i);
            cyc();
        end
        chk("fullpp_last", int'(rd_data), 8'h77);
        cyc();
        rd_ready = 1'b0;
        chk("fullpp_empty", int'(empty), 1);

        // Pointer wrap: 40 push/pop pairs
        for (int i = 0; i < 40; i++) begin
            rx_data = 8'(8'h40 + i); rx_done = 1'b1; rd_ready = 1'b0;
            cyc();
            rx_done = 1'b0;
            chk($sformatf("wrap%0d_data", i), int'(rd_data), 8'h40 + i);
            if (count > 5'd1) chk($sformatf("wrap%0d_cnt", i), int'(count), 1);
            rd_ready = 1'b1;
            cyc();
            rd_ready = 1'b0;
        end
        chk("wrap_empty", int'(empty), 1);

        // Push and pop together at count==1
        push_byte(8'hC1);
        rx_data = 8'hC2; rx_done = 1'b1; rd_ready = 1'b1;
        cyc();
        rx_done = 1'b0; rd_ready = 1'b0;
        chk("one_pp_count", int'(count), 1);
        chk("one_pp_head", int'(rd_data), 8'hC2);
        cyc();

        // Asynchronous reset mid-fill
        push_byte(8'hD1);
        push_byte(8'hD2);
        chk("midfill_count", int'(count), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_valid", int'(rd_valid), 0);
        chk("arst_ovf", int'(overflow), 0);
        cyc();
        rst = 1'b0;
        push_byte(8'h5A);
        chk("post_rst_data", int'(rd_data), 8'h5A);
        chk("post_rst_count", int'(count), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
